// File: rtl/sram_pkg.sv
// Shared constants and types for the SRAM read sequencer.
// Voltage levels are in volts on the real-valued analog interface.
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;
    localparam real VTL = 0.4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE
    } rd_state_e;

endpackage

// File: rtl/rd_fifo.sv
// First-word-fall-through output queue for sensed words.
// Circular pointers wrap at DEPTH-1; head is zero while empty.
module rd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && !full;
    assign dout    = valid ? mem[rptr] : '0;

    // Storage, pointers and occupancy; simultaneous push/pop keeps count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_read_ctrl.sv
// Read sequencer around the SRAM sense amp: drive a row, settle,
// threshold the column voltages and queue the word for the consumer.
module sram_read_ctrl
    import sram_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int COLS       = 8,
    parameter int SETTLE_CYC = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [$clog2(ROWS)-1:0] req_row,
    output real                     row_rd [0:ROWS-1],
    input  real                     preout [0:COLS-1],
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [COLS-1:0]         rd_data,
    output logic                    rd_err,
    output logic                    busy
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    rd_state_e       state;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   row_q;
    logic            ok_q;
    logic            fifo_full;
    logic            push;
    logic [COLS-1:0] samp_data;
    logic            samp_amb;
    logic [COLS:0]   push_word;
    logic [COLS:0]   head_word;

    assign busy      = (state != IDLE);
    assign req_ready = rst_n && (state == IDLE) && !fifo_full;
    assign push      = (state == SAMPLE);

    // Sequencer: accept, hold the row for the settle time, then sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            row_q <= '0;
            ok_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state <= DRIVE;
                        cnt   <= CW'(SETTLE_CYC - 1);
                        row_q <= req_row;
                        ok_q  <= (int'(req_row) < ROWS);
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // One-hot row select from the latched row; nothing driven for a bad row
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            if (busy && ok_q && (row_q == RW'(r))) begin
                row_rd[r] = VDD;
            end else begin
                row_rd[r] = VSS;
            end
        end
    end

    // Threshold each column; the band between VTL and VTH is ambiguous
    always_comb begin
        samp_data = '0;
        samp_amb  = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            samp_data[c] = (preout[c] >= VTH);
            if ((preout[c] >= VTL) && (preout[c] < VTH)) begin
                samp_amb = 1'b1;
            end
        end
    end

    assign push_word = ok_q ? {samp_amb, samp_data} : {1'b1, {COLS{1'b0}}};

    rd_fifo #(
        .WIDTH (COLS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_word),
        .pop   (rd_ready),
        .dout  (head_word),
        .valid (rd_valid),
        .full  (fifo_full)
    );

    assign {rd_err, rd_data} = head_word;

endmodule

// File: tb/tb_sram_read_ctrl.sv
// Bench for sram_read_ctrl: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_sram_read_ctrl;
    import sram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rv  [3];
    logic       rq  [3];
    logic       vld [3];
    logic       er  [3];
    logic       bz  [3];
    logic [7:0] dat [3];
    logic [3:0] req_row;
    logic       rd_ready;
    real        pre [0:7];
    real        rr0 [0:15];
    real        rr1 [0:11];
    real        rr2 [0:11];

    int pass_n = 0;
    int total_n = 0;

    always #5 clk = ~clk;

    sram_read_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rq[0]),
        .req_row(req_row), .row_rd(rr0), .preout(pre), .rd_valid(vld[0]),
        .rd_ready(rd_ready), .rd_data(dat[0]), .rd_err(er[0]), .busy(bz[0])
    );

    sram_read_ctrl #(.ROWS(12), .SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rq[1]),
        .req_row(req_row), .row_rd(rr1), .preout(pre), .rd_valid(vld[1]),
        .rd_ready(rd_ready), .rd_data(dat[1]), .rd_err(er[1]), .busy(bz[1])
    );

    sram_read_ctrl #(.ROWS(12), .SETTLE_CYC(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_ready(rq[2]),
        .req_row(req_row), .row_rd(rr2), .preout(pre), .rd_valid(vld[2]),
        .rd_ready(rd_ready), .rd_data(dat[2]), .rd_err(er[2]), .busy(bz[2])
    );

    typedef struct {
        int         row;
        logic [7:0] hi;
        int         sc;
        real        sv;
        logic [7:0] d;
        logic       e;
    } vec_t;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_n++;
        if (act === exp) begin
            pass_n++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit row_is(int k, int sel);
        bit ok = 1'b1;
        case (k)
            0: for (int r = 0; r < 16; r++) if (rr0[r] != ((r == sel) ? 1.5 : 0.0)) ok = 1'b0;
            1: for (int r = 0; r < 12; r++) if (rr1[r] != ((r == sel) ? 1.5 : 0.0)) ok = 1'b0;
            default: for (int r = 0; r < 12; r++) if (rr2[r] != ((r == sel) ? 1.5 : 0.0)) ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [8:0] model_word(int row, int rows);
        logic [7:0] d = '0;
        logic       e = 1'b0;
        if (row >= rows) return 9'h100;
        for (int c = 0; c < 8; c++) begin
            if (pre[c] >= 0.8) d[c] = 1'b1;
            if (pre[c] >= 0.4 && pre[c] < 0.8) e = 1'b1;
        end
        return {e, d};
    endfunction

    task automatic set_mask(logic [7:0] m);
        for (int c = 0; c < 8; c++) pre[c] = m[c] ? 1.5 : 0.0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(int k, int row);
        int n = 0;
        req_row = 4'(row);
        rv[k] = 1'b1;
        while (!rq[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rv[k] = 1'b0;
        chk($sformatf("issue_accept_d%0d", k), 64'(n < 50), 64'd1);
    endtask

    task automatic wait_valid(int k);
        int n = 0;
        while (!vld[k] && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_valid_d%0d", k), 64'(n < 30), 64'd1);
    endtask

    task automatic settle(int k, int row, int s, logic [7:0] m);
        int n = 1;
        int held = 0;
        set_mask(m);
        issue(k, row);
        while (!vld[k] && n < 20) begin
            if (row_is(k, row)) held++;
            @(negedge clk);
            n++;
        end
        chk($sformatf("settle_lat_d%0d", k), 64'(n), 64'(s + 2));
        chk($sformatf("settle_held_d%0d", k), 64'(held), 64'(s + 1));
        chk($sformatf("settle_data_d%0d", k), {55'd0, er[k], dat[k]}, {55'd0, 1'b0, m});
        chk($sformatf("settle_rowoff_d%0d", k), 64'(row_is(k, -1)), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        vec_t tv [6];
        real  vals [7];
        logic [8:0] q [$];
        bit   infl;
        bit   acc;
        bit   pp;
        int   t;
        int   mrow;
        logic [8:0] mw;

        tv[0] = '{row: 3,  hi: 8'h85, sc: -1, sv: 0.0,    d: 8'h85, e: 1'b0};
        tv[1] = '{row: 7,  hi: 8'hFF, sc: 4,  sv: 0.6,    d: 8'hEF, e: 1'b1};
        tv[2] = '{row: 0,  hi: 8'h00, sc: 1,  sv: 0.8,    d: 8'h02, e: 1'b0};
        tv[3] = '{row: 15, hi: 8'hF0, sc: 0,  sv: 0.4,    d: 8'hF0, e: 1'b1};
        tv[4] = '{row: 9,  hi: 8'h0F, sc: 3,  sv: 0.399,  d: 8'h07, e: 1'b0};
        tv[5] = '{row: 12, hi: 8'h00, sc: 6,  sv: 0.7999, d: 8'h00, e: 1'b1};
        vals = '{0.0, 0.3, 0.4, 0.6, 0.8, 1.0, 1.5};

        for (int k = 0; k < 3; k++) rv[k] = 1'b0;
        req_row  = '0;
        rd_ready = 1'b1;
        set_mask(8'h00);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(vld[0]), 64'd0);
        chk("rst_data", 64'(dat[0]), 64'd0);
        chk("rst_ready", 64'(rq[0]), 64'd0);
        chk("rst_busy", 64'(bz[0]), 64'd0);
        chk("rst_rows", 64'(row_is(0, -1)), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(rq[0]), 64'd1);

        // Reset asserted mid-DRIVE of row 5
        set_mask(8'hFF);
        issue(0, 5);
        @(negedge clk);
        chk("mid_row5", 64'(row_is(0, 5)), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rows", 64'(row_is(0, -1)), 64'd1);
        chk("arst_valid", 64'(vld[0]), 64'd0);
        chk("arst_busy", 64'(bz[0]), 64'd0);
        chk("arst_ready", 64'(rq[0]), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("arst_noword", 64'(vld[0]), 64'd0);
            chk("arst_idle", 64'(bz[0]), 64'd0);
        end

        // Vector table on the default instance
        for (int i = 0; i < 6; i++) begin
            set_mask(tv[i].hi);
            if (tv[i].sc >= 0) pre[tv[i].sc] = tv[i].sv;
            issue(0, tv[i].row);
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("v%0d_row_c%0d", i, j), 64'(row_is(0, tv[i].row)), 64'd1);
                chk($sformatf("v%0d_novalid_c%0d", i, j), 64'(vld[0]), 64'd0);
                @(negedge clk);
            end
            chk($sformatf("v%0d_valid", i), 64'(vld[0]), 64'd1);
            chk($sformatf("v%0d_data", i), 64'(dat[0]), 64'(tv[i].d));
            chk($sformatf("v%0d_err", i), 64'(er[0]), 64'(tv[i].e));
            chk($sformatf("v%0d_rowoff", i), 64'(row_is(0, -1)), 64'd1);
            @(negedge clk);
            chk($sformatf("v%0d_popped", i), 64'(vld[0]), 64'd0);
        end

        // Backpressure: two words fill the queue, third request waits
        rd_ready = 1'b0;
        set_mask(8'h02);
        issue(0, 1);
        repeat (3) @(negedge clk);
        set_mask(8'h04);
        issue(0, 2);
        repeat (3) @(negedge clk);
        chk("bp_full_valid", 64'(vld[0]), 64'd1);
        rv[0] = 1'b1;
        req_row = 4'd3;
        repeat (3) begin
            chk("bp_ready_low", 64'(rq[0]), 64'd0);
            chk("bp_idle", 64'(bz[0]), 64'd0);
            @(negedge clk);
        end
        set_mask(8'h08);
        chk("bp_head1", 64'(dat[0]), 64'h02);
        chk("bp_stable", 64'(vld[0]), 64'd1);
        rd_ready = 1'b1;
        @(negedge clk);
        chk("bp_head2", 64'(dat[0]), 64'h04);
        chk("bp_ready_back", 64'(rq[0]), 64'd1);
        @(negedge clk);
        rv[0] = 1'b0;
        chk("bp_accepted", 64'(bz[0]), 64'd1);
        chk("bp_drained", 64'(vld[0]), 64'd0);
        chk("bp_row3", 64'(row_is(0, 3)), 64'd1);
        wait_valid(0);
        chk("bp_word3", {55'd0, er[0], dat[0]}, 64'h008);
        @(negedge clk);

        // Out-of-range row on the 12-row instance
        set_mask(8'hFF);
        issue(1, 13);
        for (int j = 0; j < 2; j++) begin
            chk("bad_rows_off", 64'(row_is(1, -1)), 64'd1);
            chk("bad_busy", 64'(bz[1]), 64'd1);
            @(negedge clk);
        end
        chk("bad_valid", 64'(vld[1]), 64'd1);
        chk("bad_word", {55'd0, er[1], dat[1]}, 64'h100);
        @(negedge clk);

        // Settle sweep
        settle(1, 11, 1, 8'h5A);
        settle(2, 2, 5, 8'hC3);
        settle(0, 4, 2, 8'h3C);

        // Randomized run against the queue model
        infl = 1'b0;
        t = 0;
        mrow = 0;
        mw = '0;
        repeat (600) begin
            chk("r_ready", 64'(rq[0]), 64'(!infl && q.size() < 2));
            chk("r_valid", 64'(vld[0]), 64'(q.size() > 0));
            chk("r_busy", 64'(bz[0]), 64'(infl));
            chk("r_row", 64'(row_is(0, infl ? mrow : -1)), 64'd1);
            if (q.size() > 0) chk("r_word", {55'd0, er[0], dat[0]}, 64'(q[0]));
            if (!infl) begin
                for (int c = 0; c < 8; c++) pre[c] = vals[$urandom_range(0, 6)];
            end
            rv[0] = ($urandom_range(0, 2) != 0);
            req_row = 4'($urandom_range(0, 15));
            rd_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            acc = rv[0] && !infl && (q.size() < 2);
            pp = rd_ready && (q.size() > 0);
            if (pp) void'(q.pop_front());
            if (infl) begin
                t--;
                if (t == 0) begin
                    q.push_back(mw);
                    infl = 1'b0;
                end
            end else if (acc) begin
                infl = 1'b1;
                t = 3;
                mrow = int'(req_row);
                mw = model_word(mrow, 16);
            end
            @(negedge clk);
        end
        rv[0] = 1'b0;

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
